// File: rtl/rgb_pwm_led.sv
// Purpose : N-channel PWM LED driver with a shared prescaled timebase and per-channel OFF/STEADY/BLINK/BREATHE modes.
// Latency : a configuration write shows up on o_o one cycle after the next PWM-period boundary.
// Backpress: none; accepts one configuration write per cycle, and later writes overwrite earlier ones.
//
// Ports:
//   clk_i     single clock, rising edge
//   reset_i   synchronous active-high reset
//   we_i      configuration write strobe
//   waddr_i   target channel; writes to channels >= N are dropped
//   wdata_i   {mode[1:0], duty[WIDTH-1:0]} with modes 0 OFF, 1 STEADY, 2 BLINK, 3 BREATHE
//   o_o       registered active-high LED drive, one bit per channel
//   period_o  one-cycle pulse in the first cycle of each PWM period
module rgb_pwm_led #(
  parameter int N               = 3,
  parameter int WIDTH           = 8,
  parameter int DIV             = 48,
  parameter int BLINK_PERIODS   = 1953,
  parameter int BREATHE_PERIODS = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             we_i,
  input  logic [2:0]       waddr_i,
  input  logic [WIDTH+1:0] wdata_i,
  output logic [N-1:0]     o_o,
  output logic             period_o
);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_STEADY  = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

  typedef struct packed {
    mode_e            mode;
    logic [WIDTH-1:0] duty;
  } cfg_t;

  localparam cfg_t CFG_RST = '{mode: MODE_OFF, duty: '0};

  // Counter widths, kept at least 1 bit so the degenerate parameter values still elaborate.
  localparam int PSC_W = (DIV > 1)             ? $clog2(DIV)             : 1;
  localparam int BLK_W = (BLINK_PERIODS > 1)   ? $clog2(BLINK_PERIODS)   : 1;
  localparam int BRE_W = (BREATHE_PERIODS > 1) ? $clog2(BREATHE_PERIODS) : 1;

  localparam logic [PSC_W-1:0] PSC_MAX = PSC_W'(DIV - 1);
  localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(BLINK_PERIODS - 1);
  localparam logic [BRE_W-1:0] BRE_MAX = BRE_W'(BREATHE_PERIODS - 1);

  // Timebase state.
  logic [PSC_W-1:0] psc_q, psc_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [BLK_W-1:0] blk_q, blk_d;
  logic [BRE_W-1:0] bre_q, bre_d;
  logic             blink_on_q, blink_on_d;
  logic             period_q, period_d;

  // Per-channel state.
  cfg_t             shadow_q [N];
  cfg_t             shadow_d [N];
  cfg_t             active_q [N];
  cfg_t             active_d [N];
  logic [WIDTH-1:0] level_q  [N];
  logic [WIDTH-1:0] level_d  [N];
  logic [N-1:0]     up_q, up_d;
  logic [N-1:0]     o_q, o_d;

  // Combinational helpers.
  logic             tick;
  logic             boundary;
  logic             bre_step;
  logic [WIDTH-1:0] eff [N];

  // ---------------------------------------------------------------------------
  // Timebase: prescaler, PWM counter, blink phase and breathe step counter.
  // All of them are shared, which keeps every channel phase-aligned.
  // ---------------------------------------------------------------------------
  always_comb begin
    tick       = (psc_q == PSC_MAX);
    psc_d      = tick ? '0 : psc_q + 1'b1;
    cnt_d      = tick ? cnt_q + 1'b1 : cnt_q;
    // The boundary is the tick that takes the PWM counter from all-ones back to zero.
    boundary   = tick && (cnt_q == '1);
    period_d   = boundary;

    blk_d      = blk_q;
    blink_on_d = blink_on_q;
    if (boundary) begin
      if (blk_q == BLK_MAX) begin
        blk_d      = '0;
        blink_on_d = ~blink_on_q;
      end else begin
        blk_d = blk_q + 1'b1;
      end
    end

    bre_d    = bre_q;
    bre_step = boundary && (bre_q == BRE_MAX);
    if (boundary) begin
      bre_d = (bre_q == BRE_MAX) ? '0 : bre_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Configuration: writes only touch the shadow copy; the active copy reloads
  // from the pre-write shadow at a boundary, so a write on the boundary cycle
  // waits one more period.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < N; i++) begin
      shadow_d[i] = shadow_q[i];
      active_d[i] = active_q[i];
      // Matching on the index handles out-of-range addresses without a separate check.
      if (we_i && (waddr_i == 3'(i))) begin
        shadow_d[i] = cfg_t'(wdata_i);
      end
      if (boundary) begin
        active_d[i] = shadow_q[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Breathe ramp. It is evaluated at a boundary against the configuration that
  // becomes active there. Reaching either end flips direction without moving,
  // so the extreme level is held for one step.
  // ---------------------------------------------------------------------------
  always_comb begin
    up_d = up_q;
    for (int i = 0; i < N; i++) begin
      level_d[i] = level_q[i];
      if (boundary && (shadow_q[i].mode == MODE_BREATHE)) begin
        if (active_q[i].mode != MODE_BREATHE) begin
          // Entering breathe: restart the ramp from the bottom.
          level_d[i] = '0;
          up_d[i]    = 1'b1;
        end else if (bre_step) begin
          if (shadow_q[i].duty == '0) begin
            level_d[i] = '0;
            up_d[i]    = 1'b1;
          end else if (shadow_q[i].duty < level_q[i]) begin
            // The ceiling was lowered below the current level, so head down.
            up_d[i]    = 1'b0;
            level_d[i] = level_q[i] - 1'b1;
          end else if (up_q[i]) begin
            if (level_q[i] == shadow_q[i].duty) begin
              up_d[i] = 1'b0;
            end else begin
              level_d[i] = level_q[i] + 1'b1;
            end
          end else begin
            if (level_q[i] == '0) begin
              up_d[i] = 1'b1;
            end else begin
              level_d[i] = level_q[i] - 1'b1;
            end
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Compare. It works from next-state values, so o_q reflects the new period's
  // configuration in the same cycle that period_q pulses. The inputs change
  // only on ticks, so the outputs change only in the cycle after a tick.
  // ---------------------------------------------------------------------------
  always_comb begin
    o_d = '0;
    for (int i = 0; i < N; i++) begin
      eff[i] = '0;
      unique case (active_d[i].mode)
        MODE_OFF:     eff[i] = '0;
        MODE_STEADY:  eff[i] = active_d[i].duty;
        MODE_BLINK:   eff[i] = blink_on_d ? active_d[i].duty : '0;
        MODE_BREATHE: eff[i] = level_d[i];
        default:      eff[i] = '0;
      endcase
      // A strict compare means a full-scale duty still ends every period low.
      o_d[i] = (eff[i] > cnt_d);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      psc_q      <= '0;
      cnt_q      <= '0;
      blk_q      <= '0;
      bre_q      <= '0;
      blink_on_q <= 1'b1;
      period_q   <= 1'b0;
      up_q       <= '1;
      o_q        <= '0;
      for (int i = 0; i < N; i++) begin
        shadow_q[i] <= CFG_RST;
        active_q[i] <= CFG_RST;
        level_q[i]  <= '0;
      end
    end else begin
      psc_q      <= psc_d;
      cnt_q      <= cnt_d;
      blk_q      <= blk_d;
      bre_q      <= bre_d;
      blink_on_q <= blink_on_d;
      period_q   <= period_d;
      up_q       <= up_d;
      o_q        <= o_d;
      for (int i = 0; i < N; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
        level_q[i]  <= level_d[i];
      end
    end
  end

  assign o_o      = o_q;
  assign period_o = period_q;

endmodule

// File: tb/tb_rgb_pwm_led.sv
// Bench for rgb_pwm_led at N=3, WIDTH=4, DIV=2, BLINK_PERIODS=2, BREATHE_PERIODS=1.
// A period-level reference model predicts o_o/period_o every cycle; directed
// sections add per-period high-count checks against hand-derived constants.
module tb_rgb_pwm_led;

  localparam int N     = 3;
  localparam int W     = 4;
  localparam int DIV   = 2;
  localparam int BLK   = 2;
  localparam int BRP   = 1;
  localparam int TICKS = 1 << W;
  localparam int PER   = DIV * TICKS;

  logic         clk = 1'b0;
  logic         reset;
  logic         we;
  logic [2:0]   waddr;
  logic [W+1:0] wdata;
  logic [N-1:0] o;
  logic         period;

  rgb_pwm_led #(
    .N(N), .WIDTH(W), .DIV(DIV), .BLINK_PERIODS(BLK), .BREATHE_PERIODS(BRP)
  ) dut (
    .clk_i(clk), .reset_i(reset), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
    .o_o(o), .period_o(period)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_t;          // cycles since reset release
  int m_p;          // boundaries since reset release
  int sh_mode [N];
  int sh_duty [N];
  int ac_mode [N];
  int ac_duty [N];
  int lvl     [N];
  bit up      [N];

  task automatic model_reset();
    m_t = 0;
    m_p = 0;
    for (int i = 0; i < N; i++) begin
      sh_mode[i] = 0; sh_duty[i] = 0;
      ac_mode[i] = 0; ac_duty[i] = 0;
      lvl[i] = 0; up[i] = 1'b1;
    end
  endtask

  task automatic breathe_step(input int i);
    int d;
    d = ac_duty[i];
    if (d == 0) begin
      lvl[i] = 0; up[i] = 1'b1;
    end else if (d < lvl[i]) begin
      up[i] = 1'b0; lvl[i] = lvl[i] - 1;
    end else if (up[i]) begin
      if (lvl[i] == d) up[i] = 1'b0;
      else lvl[i] = lvl[i] + 1;
    end else begin
      if (lvl[i] == 0) up[i] = 1'b1;
      else lvl[i] = lvl[i] - 1;
    end
  endtask

  task automatic model_edge(input bit w, input int a, input int d, input bit r);
    int old;
    if (r) begin
      model_reset();
      return;
    end
    m_t++;
    if (m_t % PER == 0) begin
      m_p++;
      for (int i = 0; i < N; i++) begin
        old = ac_mode[i];
        ac_mode[i] = sh_mode[i];
        ac_duty[i] = sh_duty[i];
        if (ac_mode[i] == 3) begin
          if (old != 3) begin
            lvl[i] = 0; up[i] = 1'b1;
          end else if (m_p % BRP == 0) begin
            breathe_step(i);
          end
        end
      end
    end
    if (w && a < N) begin
      sh_mode[a] = (d >> W) & 3;
      sh_duty[a] = d & (TICKS - 1);
    end
  endtask

  function automatic int exp_eff(input int i);
    case (ac_mode[i])
      1:       return ac_duty[i];
      2:       return (((m_p / BLK) % 2) == 0) ? ac_duty[i] : 0;
      3:       return lvl[i];
      default: return 0;
    endcase
  endfunction

  function automatic int exp_o();
    int v;
    v = 0;
    for (int i = 0; i < N; i++) begin
      if (exp_eff(i) > ((m_t / DIV) % TICKS)) v = v | (1 << i);
    end
    return v;
  endfunction

  // ---------------- stimulus helpers ----------------
  int hc [N];

  task automatic cycle(input bit w, input int a, input int d, input bit r);
    reset = r;
    we    = w;
    waddr = a[2:0];
    wdata = d[W+1:0];
    @(posedge clk);
    model_edge(w, a, d, r);
    @(negedge clk);
    check("o", int'(o), exp_o());
    check("period", int'(period), (m_t != 0 && m_t % PER == 0) ? 1 : 0);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 0, 0, 1'b0);
  endtask

  task automatic do_reset();
    repeat (2) cycle(1'b0, 0, 0, 1'b1);
  endtask

  // Advance until a PERIOD pulse is observed, bounded by a little over one period.
  task automatic wait_period();
    int n;
    n = 0;
    do begin
      cycle(1'b0, 0, 0, 1'b0);
      n++;
    end while (!period && n < PER + 8);
    check("period_seen", int'(period), 1);
  endtask

  // Count high cycles per channel over the 32 cycles starting at the current one.
  // An optional write is issued in the second cycle of the period.
  task automatic count_period(input bit w, input int a, input int d);
    for (int i = 0; i < N; i++) hc[i] = int'(o[i]);
    for (int k = 0; k < PER - 1; k++) begin
      if (k == 0) cycle(w, a, d, 1'b0);
      else cycle(1'b0, 0, 0, 1'b0);
      for (int i = 0; i < N; i++) hc[i] += int'(o[i]);
    end
  endtask

  function automatic int cfg(input int mode, input int duty);
    return (mode << W) | duty;
  endfunction

  // ---------------- test sequence ----------------
  int n;
  int exp_blink [6];
  int exp_br    [10];
  int exp_mid   [7];

  initial begin
    reset = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
    exp_blink = '{30, 0, 0, 30, 30, 0};
    exp_br    = '{0, 2, 4, 6, 6, 4, 2, 0, 0, 2};
    exp_mid   = '{0, 2, 4, 2, 0, 0, 2};

    // Reset, then PERIOD pulse spacing.
    repeat (3) cycle(1'b0, 0, 0, 1'b1);
    check("rst_o", int'(o), 0);
    check("rst_period", int'(period), 0);
    n = 0;
    do begin cycle(1'b0, 0, 0, 1'b0); n++; end while (!period && n < 100);
    check("first_period_gap", n, PER);
    n = 0;
    do begin cycle(1'b0, 0, 0, 1'b0); n++; end while (!period && n < 100);
    check("second_period_gap", n, PER);

    // STEADY duty 4, then 15, then 0.
    do_reset();
    cycle(1'b1, 0, cfg(1, 4), 1'b0);
    wait_period();
    count_period(1'b1, 0, cfg(1, 15));
    check("steady4_ch0", hc[0], 8);
    check("steady4_ch1", hc[1], 0);
    check("steady4_ch2", hc[2], 0);
    wait_period();
    count_period(1'b1, 0, cfg(1, 0));
    check("steady15_ch0", hc[0], 30);
    wait_period();
    count_period(1'b0, 0, 0);
    check("steady0_ch0", hc[0], 0);

    // Write on the boundary tick lands one period late; WADDR=3 is ignored.
    cycle(1'b1, 0, cfg(1, 2), 1'b0);
    check("boundary_write_period", int'(period), 1);
    count_period(1'b1, 3, cfg(1, 15));
    check("boundary_write_hold", hc[0], 0);
    wait_period();
    count_period(1'b0, 0, 0);
    check("boundary_write_new", hc[0], 4);
    wait_period();
    count_period(1'b0, 0, 0);
    check("waddr3_ch0", hc[0], 4);
    check("waddr3_ch1", hc[1], 0);
    check("waddr3_ch2", hc[2], 0);

    // BLINK on ch1, ch2 joins later and must be in phase.
    do_reset();
    cycle(1'b1, 1, cfg(2, 15), 1'b0);
    for (int k = 0; k < 6; k++) begin
      wait_period();
      count_period(k == 1, 2, cfg(2, 15));
      check($sformatf("blink_ch1_p%0d", k), hc[1], exp_blink[k]);
      check($sformatf("blink_ch2_p%0d", k), hc[2], (k >= 2) ? exp_blink[k] : 0);
    end

    // BREATHE ramp on ch2 with duty 3.
    do_reset();
    cycle(1'b1, 2, cfg(3, 3), 1'b0);
    for (int k = 0; k < 10; k++) begin
      wait_period();
      count_period(1'b0, 0, 0);
      check($sformatf("breathe_p%0d", k), hc[2], exp_br[k]);
    end

    // Lower duty mid-ramp, then reset mid-breathe.
    do_reset();
    cycle(1'b1, 2, cfg(3, 3), 1'b0);
    for (int k = 0; k < 7; k++) begin
      wait_period();
      count_period(k == 2, 2, cfg(3, 1));
      check($sformatf("mid_breathe_p%0d", k), hc[2], exp_mid[k]);
    end
    wait_period();
    idle(5);
    repeat (3) cycle(1'b1, 2, cfg(1, 9), 1'b1);
    check("mid_reset_o", int'(o), 0);
    check("mid_reset_period", int'(period), 0);
    for (int k = 0; k < 2; k++) begin
      wait_period();
      count_period(1'b0, 0, 0);
      check($sformatf("post_reset_ch2_p%0d", k), hc[2], 0);
      check($sformatf("post_reset_ch0_p%0d", k), hc[0], 0);
    end

    // Randomized traffic against the model.
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      cycle($urandom_range(0, 23) == 0,
            int'($urandom_range(0, 7)),
            int'($urandom_range(0, 63)),
            $urandom_range(0, 799) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rgb_pwm_led.md
# rgb_pwm_led

Parametrised N-channel LED driver for the UPduino RGB LED, clocked from the SB_HFOSC domain. It replaces the free-running blink counter with a prescaled PWM timebase and per-channel brightness and mode (off / steady / blink / breathe). Each channel has its own configuration register. All channels share one timebase, so they stay phase-aligned. Outputs drive LED_R/LED_G/LED_B, or their driver enables, directly.

## Interface
- N, 3: number of LED channels (1..8).
- WIDTH, 8: PWM resolution in bits. The PWM period is 2^WIDTH ticks.
- DIV, 48: CLK cycles per PWM tick (≥1). At 48 MHz with the defaults, the PWM frequency is about 3.9 kHz.
- BLINK_PERIODS, 1953: PWM periods per blink half-phase (≥1). With the defaults this is about 0.5 s on and 0.5 s off.
- BREATHE_PERIODS, 8: PWM periods per breathe step (≥1).
- CLK  in  1  single clock, rising edge.
- RESET  in  1  synchronous, active-high reset.
- WE  in  1  configuration write strobe, sampled on CLK.
- WADDR  in  3  target channel index. Writes with WADDR ≥ N are ignored.
- WDATA  in  WIDTH+2  {mode[1:0], duty[WIDTH-1:0]}. Modes: 0 OFF, 1 STEADY, 2 BLINK, 3 BREATHE.
- O  out  N  LED drive per channel, active-high, registered.
- PERIOD  out  1  one-cycle pulse on each PWM period wrap.

## Operation
- **Prescaler.** Counts 0..DIV-1 and wraps. A tick is asserted in the cycle where the prescaler equals DIV-1. DIV=1 gives a tick every cycle.
- **PWM counter.** WIDTH bits, advances by 1 on each tick.
  - The boundary is the tick on which the counter wraps from 2^WIDTH-1 to 0.
  - PERIOD is registered high for exactly the one cycle following the boundary tick.
- **Configuration registers.** Each channel has a shadow register written by WE, and an active register.
  - At every boundary, active ← shadow for all channels.
  - A write in the same cycle as a boundary tick lands in shadow only. It becomes active at the next boundary.
- **Effective duty per channel**, selected by the active mode:
  - OFF: 0.
  - STEADY: duty.
  - BLINK: duty while the global blink phase is ON, 0 while it is OFF.
  - BREATHE: the per-channel level.
- **Blink phase.** One global flag, ON after reset. It toggles at every BLINK_PERIODS-th boundary, using a period counter that wraps at BLINK_PERIODS-1.
- **Breathe.** Each channel has a level (WIDTH bits) and a direction (up after reset).
  - The level moves by 1 every BREATHE_PERIODS boundaries. The breathe step counter is global.
  - At level == duty while going up, direction flips to down. At level == 0 while going down, direction flips to up. The extreme value is held for one step.
  - If duty is below the current level (duty lowered mid-ramp), direction is forced down.
  - On entering BREATHE from any other mode, the level resets to 0 with direction up. This happens at the boundary where the new mode becomes active.
  - With duty = 0 in BREATHE, the level stays at 0.
- **Compare.** O[i] is registered as (effective_duty[i] > pwm_cnt).
  - Duty 0 gives constant 0.
  - Duty 2^WIDTH-1 gives high for 2^WIDTH-1 of 2^WIDTH ticks.
  - Full-on is not reachable. This is intentional: every period ends low.

## Timing
- Reset values:
  - O = 0, PERIOD = 0.
  - Prescaler, PWM counter, blink and breathe counters = 0.
  - Blink phase = ON.
  - All shadow and active registers = {OFF, 0}.
  - All levels = 0, direction up.
- RESET mid-period takes precedence over WE in the same cycle and discards pending shadow writes.
- Latency from a write to a visible change: the next boundary, plus 1 cycle for the registered compare.
  - Worst case is DIV·2^WIDTH + 1 cycles.
- O[i] changes only on the cycle after a tick. Between ticks O is stable, so glitches are impossible by construction.
- PERIOD asserts in the same cycle that newly active configuration first affects O.
- Blink and breathe updates occur at a boundary and are visible in O from the first compare of the new period.
- Throughput: one configuration write per cycle. Back-to-back writes to the same channel before a boundary: the last one wins.

## Test plan
All scenarios use N=3, WIDTH=4, DIV=2, BLINK_PERIODS=2, BREATHE_PERIODS=1.

- **Reset.** Hold RESET 3 cycles. Require O=000 and PERIOD=0. Then require PERIOD pulses every 32 cycles, with the first pulse 32 cycles after release.
- **STEADY duty.** Write ch0 = {1, 4}. After the next PERIOD pulse, require O[0] high for exactly 8 cycles of each 32, and O[2:1]=00. Duty 15 gives 30 of 32 cycles high. Duty 0 gives constant low.
- **Write timing.** Issue a write coincident with the boundary tick. Require no change for that period, then the new duty from the following PERIOD onward. Also write WADDR=3 and require no channel to change.
- **BLINK.** Write ch1 = {2, 15}. Require two PWM periods at 30/32 high, then two periods fully low, repeating. Write ch2 = {2, 15} and require ch2 in phase with ch1.
- **BREATHE.** Write ch2 = {3, 3}. Require per-period high-cycle counts of 0, 2, 4, 6, 6, 4, 2, 0, 0, 2, …
- **Mid-breathe changes.** Lower duty to 1 mid-ramp and require the ramp to descend. Assert RESET mid-breathe and require all outputs low and configuration cleared.
